// File: rtl/sand_mem_pkg.sv
// Shared types for the sand SDRAM arbiter: widths, requester IDs, command record and FSM states.
package sand_mem_pkg;

    localparam int MEM_AW  = 24;
    localparam int MEM_DW  = 16;
    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_HPS  = 2'd0,
        REQ_VGA  = 2'd1,
        REQ_PHYS = 2'd2
    } req_id_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_cmd_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [1:0] id);
        logic [NUM_REQ-1:0] vec;
        case (id)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

    // First eligible requester in the given search order; falls through to the last entry.
    function automatic logic [1:0] pick_first(input logic [NUM_REQ-1:0] elig,
                                              input logic [1:0] first,
                                              input logic [1:0] second,
                                              input logic [1:0] third);
        logic [1:0] sel;
        if (elig[first]) begin
            sel = first;
        end else if (elig[second]) begin
            sel = second;
        end else begin
            sel = third;
        end
        return sel;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester tags for reads that are in flight on the SDRAM bus.
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [1:0] push_tag,
    input  logic       pop,
    output logic [1:0] pop_tag,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [1:0]    tags_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign do_pop_s  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push on a full FIFO is still taken.
    assign do_push_s = push & (~full | do_pop_s);
    assign pop_tag   = tags_r[rd_ptr_r];

    // Tag storage, pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags_r[i] <= 2'b00;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                tags_r[wr_ptr_r] <= push_tag;
                wr_ptr_r         <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sand_mem_arbiter.sv
// Three-way SDRAM Avalon-MM arbiter (HPS, VGA, physics) with in-order read return routing.
// Build option SAND_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority with physics aging.
module sand_mem_arbiter
    import sand_mem_pkg::*;
#(
    parameter int MEM_AW          = sand_mem_pkg::MEM_AW,
    parameter int MEM_DW          = sand_mem_pkg::MEM_DW,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][MEM_AW-1:0] req_addr,
    input  logic [NUM_REQ-1:0][MEM_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_gnt,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [MEM_DW-1:0]              rsp_data,
    output logic [MEM_AW-1:0]              mem_address,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [MEM_DW-1:0]              mem_writedata,
    input  logic                           mem_waitrequest,
    input  logic                           mem_readdatavalid,
    input  logic [MEM_DW-1:0]              mem_readdata,
    output logic                           protocol_err
);

    arb_state_t          state_r, state_nxt_s;
    req_id_t             winner_r, winner_nxt_s, win_id_s;
    logic                win_valid_s;
    logic [NUM_REQ-1:0]  eligible_s;
    logic [NUM_REQ-1:0]  gnt_s;
    mem_cmd_t            cmd_sel_s;

    logic                mem_read_r, mem_read_nxt_s;
    logic                mem_write_r, mem_write_nxt_s;
    logic [MEM_AW-1:0]   mem_address_r, mem_address_nxt_s;
    logic [MEM_DW-1:0]   mem_writedata_r, mem_writedata_nxt_s;

    logic                tag_push_s, tag_pop_s, tag_full_s, tag_empty_s;
    logic [1:0]          tag_head_s;

    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [MEM_DW-1:0]   rsp_data_r;
    logic                protocol_err_r;

    assign req_gnt       = gnt_s;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign mem_address   = mem_address_r;
    assign mem_writedata = mem_writedata_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign protocol_err  = protocol_err_r;

    // Reads need a free tag slot; writes are always eligible
    always_comb begin
        eligible_s = req & (req_we | {NUM_REQ{~tag_full_s}});
    end

`ifdef SAND_ARB_ROUND_ROBIN_EN
    req_id_t last_winner_r;

    // Round-robin search starting after the most recently granted requester
    always_comb begin
        win_valid_s = |eligible_s;
        case (last_winner_r)
            REQ_HPS: win_id_s = req_id_t'(pick_first(eligible_s, 2'd1, 2'd2, 2'd0));
            REQ_VGA: win_id_s = req_id_t'(pick_first(eligible_s, 2'd2, 2'd0, 2'd1));
            default: win_id_s = req_id_t'(pick_first(eligible_s, 2'd0, 2'd1, 2'd2));
        endcase
    end

    // Remember the last granted requester; reset value makes HPS first in line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_winner_r <= REQ_PHYS;
        end else if (gnt_s != 3'b000) begin
            last_winner_r <= winner_r;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             starve_hit_s;
    logic             phys_win_s;

    assign starve_hit_s = (starve_cnt_r >= STARVE_MAX);

    // Fixed priority HPS > VGA > physics, unless physics has aged out
    always_comb begin
        win_valid_s = |eligible_s;
        if (starve_hit_s && eligible_s[2]) begin
            win_id_s = REQ_PHYS;
        end else begin
            win_id_s = req_id_t'(pick_first(eligible_s, 2'd0, 2'd1, 2'd2));
        end
    end

    // Whether physics owns the current arbitration (IDLE) or the command in flight (ISSUE)
    always_comb begin
        if (state_r == ST_IDLE) begin
            phys_win_s = win_valid_s && (win_id_s == REQ_PHYS);
        end else begin
            phys_win_s = (winner_r == REQ_PHYS);
        end
    end

    // Physics aging counter, saturating at the starvation limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!req[2] || gnt_s[2]) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!phys_win_s && (starve_cnt_r < STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    // Command fields of the current arbitration winner
    always_comb begin
        cmd_sel_s.we    = req_we[win_id_s];
        cmd_sel_s.addr  = req_addr[win_id_s];
        cmd_sel_s.wdata = req_wdata[win_id_s];
    end

    // Next state, next bus command, grant pulse and tag push
    always_comb begin
        state_nxt_s         = state_r;
        winner_nxt_s        = winner_r;
        mem_read_nxt_s      = mem_read_r;
        mem_write_nxt_s     = mem_write_r;
        mem_address_nxt_s   = mem_address_r;
        mem_writedata_nxt_s = mem_writedata_r;
        gnt_s               = 3'b000;
        tag_push_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    winner_nxt_s        = win_id_s;
                    mem_read_nxt_s      = ~cmd_sel_s.we;
                    mem_write_nxt_s     = cmd_sel_s.we;
                    mem_address_nxt_s   = cmd_sel_s.addr;
                    mem_writedata_nxt_s = cmd_sel_s.wdata;
                    state_nxt_s         = ST_ISSUE;
                end else begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                // Accepted this cycle: grant now, drop the command on the next edge
                if (!mem_waitrequest) begin
                    gnt_s           = id_onehot(winner_r);
                    tag_push_s      = mem_read_r;
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered Avalon command outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            winner_r        <= REQ_HPS;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_address_r   <= {MEM_AW{1'b0}};
            mem_writedata_r <= {MEM_DW{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            winner_r        <= winner_nxt_s;
            mem_read_r      <= mem_read_nxt_s;
            mem_write_r     <= mem_write_nxt_s;
            mem_address_r   <= mem_address_nxt_s;
            mem_writedata_r <= mem_writedata_nxt_s;
        end
    end

    assign tag_pop_s = mem_readdatavalid & ~tag_empty_s;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (tag_push_s),
        .push_tag (winner_r),
        .pop      (tag_pop_s),
        .pop_tag  (tag_head_s),
        .full     (tag_full_s),
        .empty    (tag_empty_s)
    );

    // Route returned read data to its owner; an untagged return is dropped and flagged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_r    <= 3'b000;
            rsp_data_r     <= {MEM_DW{1'b0}};
            protocol_err_r <= 1'b0;
        end else if (mem_readdatavalid && !tag_empty_s) begin
            rsp_valid_r <= id_onehot(tag_head_s);
            rsp_data_r  <= mem_readdata;
        end else begin
            rsp_valid_r <= 3'b000;
            if (mem_readdatavalid) begin
                protocol_err_r <= 1'b1;
            end else begin
                protocol_err_r <= protocol_err_r;
            end
        end
    end

endmodule

// File: tb/tb_sand_mem_arbiter.sv
// Self-checking bench for sand_mem_arbiter: Avalon slave model plus an in-order read-response scoreboard.
module tb_sand_mem_arbiter;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int LAT = 5;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [2:0]          req;
    logic [2:0]          req_we;
    logic [2:0][AW-1:0]  req_addr;
    logic [2:0][DW-1:0]  req_wdata;
    logic [2:0]          req_gnt;
    logic [2:0]          rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic [AW-1:0]       mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [DW-1:0]       mem_writedata;
    logic                mem_waitrequest;
    logic                mem_readdatavalid;
    logic [DW-1:0]       mem_readdata;
    logic                protocol_err;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    exp_t exp_q[$];
    ret_t ret_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   allow_ret = -1;
    bit   inject    = 1'b0;

    always #5 clock = ~clock;

    sand_mem_arbiter #(
        .MEM_AW          (AW),
        .MEM_DW          (DW),
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (64)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req               (req),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_gnt           (req_gnt),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .protocol_err      (protocol_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        if (a == 24'h000000)      return 16'h1111;
        else if (a == 24'h000001) return 16'h2222;
        else                      return {a[7:0], 8'h5A};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_gnt(input int idx, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            if (req_gnt[idx]) found = 1'b1;
        end
        check_val(tag, found, 1);
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
            @(negedge clock);
            #1;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [AW-1:0] a);
        exp_t e;
        e.id   = id;
        e.data = model_data(a);
        exp_q.push_back(e);
    endtask

    // Avalon slave: records accepted reads, returns them after LAT cycles when allowed
    initial begin
        ret_t r;
        mem_readdatavalid = 1'b0;
        mem_readdata      = 16'h0000;
        forever begin
            @(negedge clock);
            if (!reset && mem_read && !mem_waitrequest) begin
                r.due  = cyc + 1 + LAT;
                r.data = model_data(mem_address);
                ret_q.push_back(r);
            end
            @(posedge clock);
            cyc++;
            #1;
            if (inject) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = 16'hDEAD;
                inject            = 1'b0;
            end else if (ret_q.size() > 0 && ret_q[0].due <= cyc && allow_ret != 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = ret_q[0].data;
                void'(ret_q.pop_front());
                if (allow_ret > 0) allow_ret--;
            end else begin
                mem_readdatavalid = 1'b0;
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expected read
    always @(negedge clock) begin
        exp_t e;
        if (!reset && rsp_valid != 3'b000) begin
            if (exp_q.size() == 0) begin
                check_val("unexp_rsp", rsp_valid, 3'b000);
            end else begin
                e = exp_q.pop_front();
                check_val("rsp_id", rsp_valid, 3'b001 << e.id);
                check_val("rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n_hps, n_vga, n_rd, n_rv;
        bit  found;
        req             = 3'b000;
        req_we          = 3'b000;
        req_addr        = '0;
        req_wdata       = '0;
        mem_waitrequest = 1'b0;
        reset           = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_ctrl", {mem_read, mem_write, req_gnt, rsp_valid, protocol_err}, 0);
        check_val("rst_addr", mem_address, 0);
        check_val("rst_data", {mem_writedata, rsp_data}, 0);
        step();
        reset = 1'b0;
        repeat (2) step();

        // HPS write held off by three waitrequest cycles
        req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 24'h000050; req_wdata[0] = 16'h00FF;
        mem_waitrequest = 1'b1;
        @(negedge clock);
        check_val("t1_pre_write", mem_write, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            mem_waitrequest = (i == 3) ? 1'b0 : 1'b1;
            @(negedge clock);
            check_val("t1_write", {mem_write, mem_read}, 2'b10);
            check_val("t1_addr", mem_address, 24'h000050);
            check_val("t1_wdata", mem_writedata, 16'h00FF);
            check_val("t1_gnt", req_gnt, (i == 3) ? 3'b001 : 3'b000);
        end
        step();
        req[0] = 1'b0;
        @(negedge clock);
        check_val("t1_release", {mem_write, mem_read, req_gnt}, 0);

        // VGA back-to-back reads with in-order returns
        step();
        req_we[1] = 1'b0; req_addr[1] = 24'h000000; req[1] = 1'b1;
        push_exp(2'd1, 24'h000000);
        wait_gnt(1, "t2_gnt0");
        step();
        req_addr[1] = 24'h000001;
        push_exp(2'd1, 24'h000001);
        wait_gnt(1, "t2_gnt1");
        step();
        req[1] = 1'b0;
        wait_drain("t2_drain");

        // All three requesting continuously: physics ages to the top after 64 cycles
        repeat (3) step();
        req_we = 3'b111;
        req_addr[0] = 24'h000100; req_addr[1] = 24'h000200; req_addr[2] = 24'h000300;
        req = 3'b111;
        n_hps = 0; n_vga = 0; found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clock);
            if (req_gnt[2]) begin
                found = 1'b1;
                check_val("t3_phys_addr", mem_address, 24'h000300);
            end else begin
                if (req_gnt[0]) n_hps++;
                if (req_gnt[1]) n_vga++;
            end
        end
        check_val("t3_phys_gnt", found, 1);
        check_val("t3_hps_before", n_hps, 32);
        check_val("t3_vga_before", n_vga, 0);
        step();
        req = 3'b000;

        // Tag FIFO full: fifth read masked, HPS write still granted
        allow_ret = 0;
        repeat (2) step();
        req_we = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            req_addr[1] = 24'(16 + i);
            req[1]      = 1'b1;
            push_exp(2'd1, 24'(16 + i));
            wait_gnt(1, "t4_gnt_rd");
        end
        step();
        req_addr[1] = 24'h000014;
        push_exp(2'd1, 24'h000014);
        req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 24'h000060; req_wdata[0] = 16'hBEEF;
        wait_gnt(0, "t4_hps_gnt");
        step();
        req[0] = 1'b0;
        n_rd = 0;
        repeat (10) begin
            @(negedge clock);
            if (mem_read || req_gnt[1]) n_rd++;
        end
        check_val("t4_masked", n_rd, 0);
        check_val("t4_no_rsp_yet", exp_q.size(), 5);
        allow_ret = 1;
        wait_gnt(1, "t4_gnt_5th");
        allow_ret = -1;
        step();
        req[1] = 1'b0;
        wait_drain("t4_drain");

        // Return with nothing outstanding
        repeat (3) step();
        @(negedge clock);
        check_val("t5_err_before", protocol_err, 0);
        inject = 1'b1;
        n_rv = 0;
        repeat (4) begin
            @(negedge clock);
            if (rsp_valid != 3'b000) n_rv++;
        end
        check_val("t5_no_rsp", n_rv, 0);
        check_val("t5_err", protocol_err, 1);
        repeat (5) @(negedge clock);
        check_val("t5_err_sticky", protocol_err, 1);

        // Reset in the middle of a stalled physics read
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check_val("t6_err_cleared", protocol_err, 0);
        step();
        mem_waitrequest = 1'b1;
        req_we[2] = 1'b0; req_addr[2] = 24'h000030; req[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            if (mem_read) found = 1'b1;
        end
        check_val("t6_issue", found, 1);
        reset = 1'b1;
        #1;
        check_val("t6_async_read", mem_read, 0);
        check_val("t6_async_addr", mem_address, 0);
        step();
        req = 3'b000;
        mem_waitrequest = 1'b0;
        step();
        reset = 1'b0;
        repeat (2) step();
        @(negedge clock);
        inject = 1'b1;
        n_rv = 0;
        repeat (3) begin
            @(negedge clock);
            if (rsp_valid != 3'b000) n_rv++;
        end
        check_val("t6_no_rsp", n_rv, 0);
        check_val("t6_err", protocol_err, 1);

        check_val("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sand_mem_arbiter.md
Name: sand_mem_arbiter

Overview:
Shares the single SDRAM Avalon-MM master between three requesters: HPS paint writes, the VGA line prefetcher and the physics sweep engine. It issues one command at a time while holding it stable under mem_waitrequest. It tracks outstanding pipelined reads in a tag FIFO and routes each mem_readdatavalid beat back to the requester that issued it. It sits between the sand top-level sequencing logic and the SDRAM master ports.

Parameters:
MEM_AW, 24, SDRAM word address width
MEM_DW, 16, SDRAM data width
MAX_OUTSTANDING, 4, maximum in-flight reads (power of 2, at least 2)
STARVE_LIMIT, 64, cycles a pending physics request waits before it is promoted to top priority

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  3  per-requester request; [0]=HPS, [1]=VGA, [2]=physics
req_we  in  3  per-requester write enable (1=write, 0=read)
req_addr  in  3xMEM_AW  per-requester word address
req_wdata  in  3xMEM_DW  per-requester write data
req_gnt  out  3  one-cycle pulse: command accepted by SDRAM (waitrequest low)
rsp_valid  out  3  one-cycle pulse: read data for that requester
rsp_data  out  MEM_DW  read data, shared, qualified by rsp_valid
mem_address  out  MEM_AW  Avalon address
mem_read  out  1  Avalon read
mem_write  out  1  Avalon write
mem_writedata  out  MEM_DW  Avalon write data
mem_waitrequest  in  1  Avalon stall
mem_readdatavalid  in  1  Avalon read return
mem_readdata  in  MEM_DW  Avalon read data
protocol_err  out  1  sticky flag: readdatavalid seen with empty tag FIFO

Behaviour:
- Clock and reset: single clock domain, port clock. Reset is asynchronous and active-high, port reset. The reset values listed below are applied on assertion, independent of the clock.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, req_gnt=0, rsp_valid=0, rsp_data=0, protocol_err=0. Tag FIFO empty, starvation counter 0, FSM in IDLE.
- FSM states:
  - IDLE: arbitrate among eligible requests. A read request is eligible only if the tag FIFO is not full. On a winner, register address, data and command into the mem_* outputs and go to ISSUE. The command appears on the bus the cycle after the request is sampled.
  - ISSUE: hold all mem_* outputs stable while mem_waitrequest=1. On the first cycle with mem_waitrequest=0:
    - pulse req_gnt[winner] in that same cycle;
    - on a read, push the winner ID into the tag FIFO;
    - deassert mem_read/mem_write on the next cycle and return to IDLE.
  - Net: one command per two cycles at best.
- Priority: fixed order HPS > VGA > physics.
- Starvation counter: increments each IDLE/ISSUE cycle in which req[2]=1 and physics is not the winner; saturates at STARVE_LIMIT. At STARVE_LIMIT, physics wins the next arbitration. The counter clears when physics is granted or req[2]=0.
- Requester contract: a requester holds req, req_we, req_addr and req_wdata stable until its req_gnt pulse. It may drop req in the cycle after req_gnt, or keep it high for back-to-back commands.
- Read return:
  - On mem_readdatavalid, pop the tag FIFO and pulse rsp_valid[tag]. rsp_data is registered, so rsp_valid and rsp_data appear 1 cycle after mem_readdatavalid.
  - Returns are strictly in order.
  - Push and pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- Boundaries:
  - Tag FIFO full: reads are masked from arbitration. Writes still proceed.
  - mem_readdatavalid with tag FIFO empty: data dropped, no rsp_valid, protocol_err set until reset.
  - Reset mid-ISSUE: command deasserts immediately and tags are flushed. Returns arriving after reset are dropped and flag protocol_err.
  - All req=0: remain in IDLE, with mem_read=mem_write=0.

Optional Feature:
SAND_ARB_ROUND_ROBIN_EN
- Defined: arbitration is round-robin starting after the last winner. The starvation counter and STARVE_LIMIT are unused.
- Undefined: fixed priority with physics aging, as specified above.
- Ports and FSM timing are identical in both builds.

Decomposition:
- Package sand_mem_pkg holds:
  - MEM_AW and MEM_DW constants;
  - requester ID typedef, 2-bit enum REQ_HPS=0, REQ_VGA=1, REQ_PHYS=2;
  - shared command struct {we, addr, wdata}.
- One sub-module, arb_tag_fifo: depth MAX_OUTSTANDING, 2-bit entries, with push, pop, full, empty and simultaneous push/pop support.

Test Plan:
- Single HPS write addr 0x000050 data 0x00FF, waitrequest held high 3 cycles -> mem_write with stable addr/data for 4 cycles; req_gnt[0] pulses in the 4th cycle; mem_write low the next cycle.
- VGA reads 0x000000, 0x000001 back-to-back, readdatavalid returns 0x1111, 0x2222 with latency 5 -> rsp_valid[1] twice, rsp_data 0x1111 then 0x2222 in order.
- All three requesters held high continuously, STARVE_LIMIT=64 -> physics granted on the first arbitration after its counter hits 64; HPS/VGA wins before that.
- 4 VGA reads outstanding with no return -> the 5th read is not issued, while a concurrent HPS write is granted. One return -> 5th read issues.
- mem_readdatavalid pulse with no outstanding read -> no rsp_valid, protocol_err=1 and remains 1 until reset.
- Reset asserted mid-ISSUE of a physics read -> mem_read=0 asynchronously. A later return produces no rsp_valid and sets protocol_err.
